// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: issue, operand and write-back signals of the ALU operand stage.
//   issue:      issue_valid, issue_ready, rd_addr1, rd_addr2, opcode_in
//   operand:    op_valid, op_ready, in1, in2, opcode
//   write-back: wb_en, wb_addr, wb_data, wb_negative, wb_zero, flag_negative, flag_zero
//   master = upstream/ALU side, slave = the operand stage
interface alu_operand_stage_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);
  logic             issue_valid;
  logic             issue_ready;
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [3:0]       opcode_in;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       opcode;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_negative;
  logic             wb_zero;
  logic             flag_negative;
  logic             flag_zero;
  modport master (
    output issue_valid, rd_addr1, rd_addr2, opcode_in, op_ready,
           wb_en, wb_addr, wb_data, wb_negative, wb_zero,
    input  issue_ready, op_valid, in1, in2, opcode, flag_negative, flag_zero
  );
  modport slave (
    input  issue_valid, rd_addr1, rd_addr2, opcode_in, op_ready,
           wb_en, wb_addr, wb_data, wb_negative, wb_zero,
    output issue_ready, op_valid, in1, in2, opcode, flag_negative, flag_zero
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register file plus operand pipeline register feeding the 4-bit ALU.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of alu_operand_stage_if (issue, operand and write-back ports)
module alu_operand_stage #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_operand_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [AW-1:0]    src1_q, src1_d, src2_q, src2_d;
  logic             op_valid_q, op_valid_d;
  logic             flag_negative_q, flag_zero_q;
  logic             fire, stall;
  logic [WIDTH-1:0] rd1, rd2;
  assign bus.issue_ready   = !op_valid_q || bus.op_ready;
  assign fire              = bus.issue_valid && bus.issue_ready;
  assign stall             = op_valid_q && !bus.op_ready;
  // a write-back in the fire cycle overrides the stale register value
  assign rd1 = (bus.wb_en && bus.wb_addr == bus.rd_addr1) ? bus.wb_data : regs_q[bus.rd_addr1];
  assign rd2 = (bus.wb_en && bus.wb_addr == bus.rd_addr2) ? bus.wb_data : regs_q[bus.rd_addr2];
  always_comb begin
    // a stalled operand tracks write-backs to its source register; opcode never does
    in1_d      = fire ? rd1 : (stall && bus.wb_en && bus.wb_addr == src1_q) ? bus.wb_data : in1_q;
    in2_d      = fire ? rd2 : (stall && bus.wb_en && bus.wb_addr == src2_q) ? bus.wb_data : in2_q;
    opcode_d   = fire ? bus.opcode_in : opcode_q;
    src1_d     = fire ? bus.rd_addr1 : src1_q;
    src2_d     = fire ? bus.rd_addr2 : src2_q;
    op_valid_d = fire || stall;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_q      <= '0;
      in2_q      <= '0;
      opcode_q   <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      opcode_q   <= opcode_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      op_valid_q <= op_valid_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flag_negative_q <= 1'b0;
      flag_zero_q     <= 1'b0;
    end else if (bus.wb_en) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
      flag_negative_q     <= bus.wb_negative;
      flag_zero_q         <= bus.wb_zero;
    end
  end
  assign bus.op_valid      = op_valid_q;
  assign bus.in1           = in1_q;
  assign bus.in2           = in2_q;
  assign bus.opcode        = opcode_q;
  assign bus.flag_negative = flag_negative_q;
  assign bus.flag_zero     = flag_zero_q;
endmodule
